// File: rtl/cfu_multi_pkg.sv
// Shared types and constants for the multi-function CFU (cfu_multi_unit).
package cfu_multi_pkg;

  localparam int CFU_XLEN = 32;
  localparam int CFU_ID_W = 4;

  localparam logic [2:0] CFU_STATUS_OK      = 3'd0;
  localparam logic [2:0] CFU_STATUS_ILLEGAL = 3'd1;

  typedef enum logic [2:0] {
    CFU_FUNC_XNOR   = 3'd0,
    CFU_FUNC_XOR    = 3'd1,
    CFU_FUNC_AND    = 3'd2,
    CFU_FUNC_OR     = 3'd3,
    CFU_FUNC_POPCNT = 3'd4,
    CFU_FUNC_MINU   = 3'd5,
    CFU_FUNC_MAXU   = 3'd6,
    CFU_FUNC_SATADD = 3'd7
  } cfu_func_t;

  typedef struct packed {
    logic [CFU_ID_W-1:0] id;
    logic [CFU_XLEN-1:0] data;
    logic [2:0]          status;
  } cfu_resp_t;

  localparam cfu_resp_t CFU_RESP_ZERO = '{
    id:     {CFU_ID_W{1'b0}},
    data:   {CFU_XLEN{1'b0}},
    status: CFU_STATUS_OK
  };

endpackage

// File: rtl/cfu_resp_fifo.sv
// First-word-fall-through response FIFO; head is forced to zero while empty.
module cfu_resp_fifo
  import cfu_multi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cfu_resp_t              push_data,
  input  logic                   pop,
  output cfu_resp_t              head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cfu_resp_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          empty_s;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop & ~empty_s;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push_s = push & (~full_s | do_pop_s);

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head       = empty_s ? CFU_RESP_ZERO : mem_r[rd_ptr_r];
  assign head_valid = ~empty_s;
  assign count      = count_r;

endmodule

// File: rtl/cfu_multi_unit.sv
// Multi-function CFU: fixed-latency datapath, credit-gated requests, FWFT response FIFO.
// Define CFU_MULTI_SAT_ADD_EN to make func 7 an unsigned saturating add (otherwise illegal).
module cfu_multi_unit
  import cfu_multi_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ID_W    = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic [2:0]      req_func,
  input  logic [XLEN-1:0] req_data0,
  input  logic [XLEN-1:0] req_data1,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic [2:0]      resp_status
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   credits_r;
  logic [CW-1:0]   credits_next_s;
  logic            req_ready_r;
  logic            accept_s;
  logic            pop_s;
  logic            push_s;
  logic            head_valid_s;
  logic [CW-1:0]   fifo_count_unused_s;
  logic [XLEN-1:0] op_and_s;
  cfu_resp_t       result_s;
  cfu_resp_t       push_data_s;
  cfu_resp_t       head_s;

  function automatic logic [XLEN-1:0] popcnt(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] n;
    n = {XLEN{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      n = n + XLEN'(v[i]);
    end
    return n;
  endfunction

  assign accept_s = req_valid & req_ready_r;
  assign pop_s    = head_valid_s & resp_ready;
  assign op_and_s = req_data0 & req_data1;

`ifdef CFU_MULTI_SAT_ADD_EN
  logic [XLEN:0]   sum_s;
  logic [XLEN-1:0] sat_sum_s;
  assign sum_s     = {1'b0, req_data0} + {1'b0, req_data1};
  assign sat_sum_s = sum_s[XLEN] ? {XLEN{1'b1}} : sum_s[XLEN-1:0];
`endif

  // Function datapath on the request operands.
  always_comb begin
    result_s        = CFU_RESP_ZERO;
    result_s.id     = CFU_ID_W'(req_id);
    result_s.status = CFU_STATUS_OK;
    case (cfu_func_t'(req_func))
      CFU_FUNC_XNOR:   result_s.data = CFU_XLEN'(~(req_data0 ^ req_data1));
      CFU_FUNC_XOR:    result_s.data = CFU_XLEN'(req_data0 ^ req_data1);
      CFU_FUNC_AND:    result_s.data = CFU_XLEN'(op_and_s);
      CFU_FUNC_OR:     result_s.data = CFU_XLEN'(req_data0 | req_data1);
      CFU_FUNC_POPCNT: result_s.data = CFU_XLEN'(popcnt(op_and_s));
      CFU_FUNC_MINU:   result_s.data = CFU_XLEN'((req_data0 < req_data1) ? req_data0 : req_data1);
      CFU_FUNC_MAXU:   result_s.data = CFU_XLEN'((req_data0 > req_data1) ? req_data0 : req_data1);
`ifdef CFU_MULTI_SAT_ADD_EN
      CFU_FUNC_SATADD: result_s.data = CFU_XLEN'(sat_sum_s);
`endif
      default: begin
        result_s.data   = {CFU_XLEN{1'b0}};
        result_s.status = CFU_STATUS_ILLEGAL;
      end
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_s      = accept_s;
      assign push_data_s = result_s;
    end else begin : g_stages
      logic [LATENCY-2:0] stage_valid_r;
      cfu_resp_t          stage_data_r [LATENCY-1];

      // Non-stalling shift pipeline between accept and FIFO write.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_valid_r <= {(LATENCY-1){1'b0}};
          for (int i = 0; i < LATENCY-1; i++) begin
            stage_data_r[i] <= CFU_RESP_ZERO;
          end
        end else begin
          stage_valid_r[0] <= accept_s;
          stage_data_r[0]  <= result_s;
          for (int i = 1; i < LATENCY-1; i++) begin
            stage_valid_r[i] <= stage_valid_r[i-1];
            stage_data_r[i]  <= stage_data_r[i-1];
          end
        end
      end

      assign push_s      = stage_valid_r[LATENCY-2];
      assign push_data_s = stage_data_r[LATENCY-2];
    end
  endgenerate

  // Credits count free FIFO slots not yet claimed by in-flight requests.
  always_comb begin
    credits_next_s = credits_r;
    if (accept_s && !pop_s) begin
      credits_next_s = credits_r - CW'(1);
    end else if (pop_s && !accept_s) begin
      credits_next_s = credits_r + CW'(1);
    end else begin
      credits_next_s = credits_r;
    end
  end

  // Credit counter and registered ready, so resp_ready never reaches req_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r   <= CW'(DEPTH);
      req_ready_r <= 1'b1;
    end else begin
      credits_r   <= credits_next_s;
      req_ready_r <= (credits_next_s != {CW{1'b0}});
    end
  end

  cfu_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .head       (head_s),
    .head_valid (head_valid_s),
    .count      (fifo_count_unused_s)
  );

  assign req_ready   = req_ready_r;
  assign resp_valid  = head_valid_s;
  assign resp_id     = ID_W'(head_s.id);
  assign resp_data   = XLEN'(head_s.data);
  assign resp_status = head_s.status;

endmodule

// File: tb/tb_cfu_multi_unit.sv
// Self-checking bench for cfu_multi_unit: directed cases plus randomized traffic against a queue model.
module tb_cfu_multi_unit;

  localparam int XLEN    = 32;
  localparam int ID_W    = 4;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [ID_W-1:0] req_id = 4'd0;
  logic [2:0]      req_func = 3'd0;
  logic [XLEN-1:0] req_data0 = 32'd0;
  logic [XLEN-1:0] req_data1 = 32'd0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [ID_W-1:0] resp_id;
  logic [XLEN-1:0] resp_data;
  logic [2:0]      resp_status;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] data;
    logic [2:0]      status;
    int              vis;
  } exp_t;

  exp_t            model_q [$];
  logic [ID_W-1:0] pop_ids [$];
  logic [XLEN-1:0] pop_data [$];
  logic [2:0]      pop_status [$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;

  cfu_multi_unit #(
    .XLEN    (XLEN),
    .ID_W    (ID_W),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_id      (req_id),
    .req_func    (req_func),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_status (resp_status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_data(input logic [2:0] f, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (f)
      3'd0: return ~(a ^ b);
      3'd1: return a ^ b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 32'($countones(a & b));
      3'd5: return (a < b) ? a : b;
      3'd6: return (a > b) ? a : b;
`ifdef CFU_MULTI_SAT_ADD_EN
      default: return sum[XLEN] ? 32'hFFFF_FFFF : sum[XLEN-1:0];
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic logic [2:0] ref_status(input logic [2:0] f);
`ifdef CFU_MULTI_SAT_ADD_EN
    return 3'd0;
`else
    return (f == 3'd7) ? 3'd1 : 3'd0;
`endif
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step();
    bit   acc;
    bit   pp;
    bit   exp_valid;
    exp_t e;
    exp_valid = (model_q.size() != 0) && (model_q[0].vis <= cyc);
    check_eq("req_ready", 32'(req_ready), 32'(model_q.size() < DEPTH));
    check_eq("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("resp_id", 32'(resp_id), 32'(model_q[0].id));
      check_eq("resp_data", resp_data, model_q[0].data);
      check_eq("resp_status", 32'(resp_status), 32'(model_q[0].status));
    end
    acc = req_valid && (model_q.size() < DEPTH);
    pp  = resp_ready && exp_valid;
    if (pp) begin
      pop_ids.push_back(resp_id);
      pop_data.push_back(resp_data);
      pop_status.push_back(resp_status);
    end
    e.id     = req_id;
    e.data   = ref_data(req_func, req_data0, req_data1);
    e.status = ref_status(req_func);
    @(posedge clk);
    cyc++;
    if (pp) void'(model_q.pop_front());
    if (acc) begin
      e.vis = cyc + LATENCY - 1;
      model_q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_q.delete();
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_id", 32'(resp_id), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_resp_status", 32'(resp_status), 32'd0);
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 60 && model_q.size() != 0; i++) step();
    if (model_q.size() != 0) check_eq("drain_timeout", 32'(model_q.size()), 32'd0);
  endtask

  task automatic clear_log();
    pop_ids.delete();
    pop_data.delete();
    pop_status.delete();
  endtask

  task automatic rand_req();
    req_id    = 4'($urandom_range(0, 15));
    req_func  = 3'($urandom_range(0, 7));
    req_data0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
    req_data1 = ($urandom_range(0, 3) == 0) ? 32'h0000_0020 : $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] exp2 [6];
    int              dut_acc;
    exp2 = '{32'hA, 32'h5, 32'hF, 32'h2, 32'h5, 32'hF};

    do_reset();

    // Single XNOR request, held at the FIFO head until checked.
    req_valid = 1'b1; req_id = 4'd3; req_func = 3'd0;
    req_data0 = 32'hF0F0_F0F0; req_data1 = 32'hFF00_FF00;
    resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) step();
    check_eq("t1_valid", 32'(resp_valid), 32'd1);
    check_eq("t1_id", 32'(resp_id), 32'd3);
    check_eq("t1_data", resp_data, 32'hF00F_F00F);
    check_eq("t1_status", 32'(resp_status), 32'd0);
    drain();

    // Back-to-back funcs 1..6.
    clear_log();
    resp_ready = 1'b1;
    req_data0 = 32'h0000_000F; req_data1 = 32'h0000_0005;
    for (int f = 1; f <= 6; f++) begin
      req_valid = 1'b1; req_id = 4'(f - 1); req_func = 3'(f);
      check_eq("t2_ready", 32'(req_ready), 32'd1);
      step();
    end
    drain();
    check_eq("t2_count", 32'(pop_ids.size()), 32'd6);
    for (int i = 0; i < 6 && i < pop_ids.size(); i++) begin
      check_eq("t2_id", 32'(pop_ids[i]), 32'(i));
      check_eq("t2_data", pop_data[i], exp2[i]);
    end

    // Fill to DEPTH with the consumer stalled, then free one slot.
    clear_log();
    resp_ready = 1'b0;
    dut_acc = 0;
    req_valid = 1'b1; req_func = 3'd1;
    for (int i = 0; i < 8; i++) begin
      req_id = 4'(8 + dut_acc);
      req_data0 = $urandom; req_data1 = $urandom;
      if (req_valid && req_ready) dut_acc++;
      step();
    end
    check_eq("t3_accepts", 32'(dut_acc), 32'(DEPTH));
    check_eq("t3_full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("t3_ready_after_pop", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_id = 4'd12;
    step();
    drain();
    check_eq("t3_count", 32'(pop_ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < pop_ids.size(); i++) check_eq("t3_id", 32'(pop_ids[i]), 32'(8 + i));

    // func 7 boundary.
    clear_log();
    req_valid = 1'b1; req_id = 4'd7; req_func = 3'd7;
    req_data0 = 32'hFFFF_FFF0; req_data1 = 32'h0000_0020;
    step();
    drain();
    check_eq("t4_count", 32'(pop_ids.size()), 32'd1);
    if (pop_ids.size() != 0) begin
`ifdef CFU_MULTI_SAT_ADD_EN
      check_eq("t4_data", pop_data[0], 32'hFFFF_FFFF);
      check_eq("t4_status", 32'(pop_status[0]), 32'd0);
`else
      check_eq("t4_data", pop_data[0], 32'd0);
      check_eq("t4_status", 32'(pop_status[0]), 32'd1);
`endif
    end

    // Steady state: always requesting, consumer toggling.
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rand_req();
      resp_ready = ~resp_ready;
      step();
    end
    drain();

    // Mixed random traffic.
    for (int i = 0; i < 300; i++) begin
      rand_req();
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset with three outstanding responses.
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      step();
    end
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 60; i++) begin
      rand_req();
      req_valid  = 1'($urandom_range(0, 1));
      resp_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
